// File: rtl/mul_div_pkg.sv
// Shared op/state encodings and iteration counts for mul_div_unit.
// MUL_DIV_RADIX4_EN selects radix-4 Booth (16 MUL iterations) instead of radix-2 (32).
package mul_div_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

`ifdef MUL_DIV_RADIX4_EN
  localparam int MUL_ITERS  = 16;
  localparam int BOOTH_BITS = 3;
`else
  localparam int MUL_ITERS  = 32;
  localparam int BOOTH_BITS = 2;
`endif

  localparam int DIV_ITERS = 32;

endpackage

// File: rtl/booth_sel.sv
// Combinational Booth recode: multiplier bits (plus the bit shifted out) -> partial product.
// Radix-4 digits {0,+-M,+-2M} under MUL_DIV_RADIX4_EN, otherwise radix-2 digits {0,+-M}.
module booth_sel
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]      i_mcand,
  input  logic [BOOTH_BITS-1:0] i_bits,
  output logic [WIDTH+1:0]      o_pp
);

  logic [WIDTH+1:0] w_m1;

  assign w_m1 = {{2{i_mcand[WIDTH-1]}}, i_mcand};

`ifdef MUL_DIV_RADIX4_EN
  logic [WIDTH+1:0] w_m2;

  assign w_m2 = {i_mcand[WIDTH-1], i_mcand, 1'b0};

  always_comb begin
    o_pp = '0;
    case (i_bits)
      3'b001, 3'b010: o_pp = w_m1;
      3'b011:         o_pp = w_m2;
      3'b100:         o_pp = -w_m2;
      3'b101, 3'b110: o_pp = -w_m1;
      default:        o_pp = '0;
    endcase
  end
`else
  always_comb begin
    o_pp = '0;
    case (i_bits)
      2'b01:   o_pp = w_m1;
      2'b10:   o_pp = -w_m1;
      default: o_pp = '0;
    endcase
  end
`endif

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle signed MUL (Booth) / DIV (non-restoring); result held until the next start.
// Latency: MUL 33 edges (17 with MUL_DIV_RADIX4_EN), DIV 33, DIV-by-zero 1; start ignored while busy.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] result
);

  // Two guard bits keep Booth partial sums and the shifted remainder from overflowing.
  localparam int AW = WIDTH + 2;

  state_t               r_state, w_next;
  logic                 r_op, r_neg_q, r_neg_r, r_dbz, r_qm1;
  logic [CNT_W-1:0]     r_cnt;
  logic [AW-1:0]        r_hi;
  logic [WIDTH-1:0]     r_lo, r_m;
  logic [2*WIDTH-1:0]   r_result;

  logic                  w_b_zero, w_last;
  logic [WIDTH-1:0]      w_a_mag, w_b_mag, w_rem, w_rem_s, w_quo;
  logic [AW-1:0]         w_pp, w_msum, w_shl, w_dsum;
  logic [BOOTH_BITS-1:0] w_bits;

  assign w_b_zero = (b == '0);
  assign w_a_mag  = a[WIDTH-1] ? -a : a;
  assign w_b_mag  = b[WIDTH-1] ? -b : b;
  assign w_last   = (r_op == OP_MUL) ? (r_cnt == CNT_W'(MUL_ITERS - 1))
                                     : (r_cnt == CNT_W'(DIV_ITERS - 1));

`ifdef MUL_DIV_RADIX4_EN
  assign w_bits = {r_lo[1:0], r_qm1};
`else
  assign w_bits = {r_lo[0], r_qm1};
`endif

  booth_sel #(.WIDTH(WIDTH)) u_booth_sel (
    .i_mcand (r_m),
    .i_bits  (w_bits),
    .o_pp    (w_pp)
  );

  assign w_msum = r_hi + w_pp;
  // Non-restoring step: r_hi is the signed partial remainder, r_lo shifts dividend out / quotient in.
  assign w_shl  = {r_hi[AW-2:0], r_lo[WIDTH-1]};
  assign w_dsum = r_hi[AW-1] ? (w_shl + {2'b00, r_m}) : (w_shl - {2'b00, r_m});

  assign w_rem   = r_hi[AW-1] ? (r_hi[WIDTH-1:0] + r_m) : r_hi[WIDTH-1:0];
  assign w_rem_s = r_neg_r ? -w_rem : w_rem;
  assign w_quo   = r_neg_q ? -r_lo : r_lo;

  always_ff @(posedge clk) begin
    if (clr) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = (r_state != ST_IDLE);
    done   = (r_state == ST_DONE);
    case (r_state)
      ST_IDLE:  if (start) w_next = ((op == OP_DIV) && w_b_zero) ? ST_FIXUP : ST_CALC;
      ST_CALC:  if (w_last) w_next = ST_FIXUP;
      ST_FIXUP: w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_op     <= OP_MUL;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dbz    <= 1'b0;
      r_qm1    <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_m      <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_op    <= op;
          r_cnt   <= '0;
          r_hi    <= '0;
          r_qm1   <= 1'b0;
          r_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
          r_neg_r <= a[WIDTH-1];
          r_dbz   <= (op == OP_DIV) && w_b_zero;
          if (op == OP_MUL) begin
            r_m  <= a;
            r_lo <= b;
          end else begin
            r_m  <= w_b_mag;
            r_lo <= w_b_zero ? a : w_a_mag;
          end
        end
        ST_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_op == OP_MUL) begin
`ifdef MUL_DIV_RADIX4_EN
            r_hi  <= {{2{w_msum[AW-1]}}, w_msum[AW-1:2]};
            r_lo  <= {w_msum[1:0], r_lo[WIDTH-1:2]};
            r_qm1 <= r_lo[1];
`else
            r_hi  <= {w_msum[AW-1], w_msum[AW-1:1]};
            r_lo  <= {w_msum[0], r_lo[WIDTH-1:1]};
            r_qm1 <= r_lo[0];
`endif
          end else begin
            r_hi <= w_dsum;
            r_lo <= {r_lo[WIDTH-2:0], ~w_dsum[AW-1]};
          end
        end
        ST_FIXUP: begin
          if (r_op == OP_MUL) r_result <= {r_hi[WIDTH-1:0], r_lo};
          else if (r_dbz)     r_result <= {r_lo, {WIDTH{1'b1}}};
          else                r_result <= {w_rem_s, w_quo};
        end
        default: ;
      endcase
    end
  end

  assign div_by_zero = r_dbz;
  assign result      = r_result;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench: stimulus pushes hand-computed results and latencies, a monitor checks each done.
module tb_mul_div_unit;

`ifdef MUL_DIV_RADIX4_EN
  localparam int MUL_LAT = 17;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;
  localparam int DBZ_LAT = 1;

  typedef struct {
    logic [63:0] res;
    logic        dbz;
    int          k;
    int          lat;
  } exp_t;

  logic        clk, clr, start, op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [63:0] result;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];

  mul_div_unit dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .result      (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] er, input logic ed, input int lat);
    exp_t e;
    wait_idle();
    op = o; a = x; b = y; start = 1'b1;
    e.res = er; e.dbz = ed; e.k = cyc + 1; e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; op = ~o; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
          chk("latency", 64'(cyc - e.k), 64'(e.lat));
          @(negedge clk);
          chk("done_one_cycle", 64'(done), 64'd0);
          chk("busy_after_done", 64'(busy), 64'd0);
        end
      end
    end
  end

  initial begin
    int t;
    clr = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_dbz", 64'(div_by_zero), 64'd0);
    chk("reset_result", result, 64'd0);
    clr = 1'b0;
    @(negedge clk);

    // MUL
    issue(1'b0, 32'd7,          32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, MUL_LAT);
    issue(1'b0, 32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, MUL_LAT);
    issue(1'b0, 32'hFFFF_FFFF,  32'd1,         64'hFFFF_FFFF_FFFF_FFFF, 1'b0, MUL_LAT);
    issue(1'b0, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b0, MUL_LAT);
    issue(1'b0, 32'h8000_0000,  32'h7FFF_FFFF, 64'hC000_0000_8000_0000, 1'b0, MUL_LAT);
    // DIV
    issue(1'b1, 32'hFFFF_FFF9,  32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 1'b0, DIV_LAT);
    issue(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, DIV_LAT);
    issue(1'b1, 32'd7,          32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0, DIV_LAT);
    issue(1'b1, 32'd100,        32'd7,         64'h0000_0002_0000_000E, 1'b0, DIV_LAT);
    issue(1'b1, 32'd3,          32'd5,         64'h0000_0003_0000_0000, 1'b0, DIV_LAT);
    issue(1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 64'hFFFF_FFFE_0000_000E, 1'b0, DIV_LAT);
    // Divide by zero, stickiness, clear by a following MUL
    issue(1'b1, 32'd5,          32'd0,         64'h0000_0005_FFFF_FFFF, 1'b1, DBZ_LAT);
    wait_idle();
    @(negedge clk);
    chk("dbz_sticky_idle", 64'(div_by_zero), 64'd1);
    issue(1'b0, 32'd2,          32'd3,         64'h0000_0000_0000_0006, 1'b0, MUL_LAT);
    chk("dbz_cleared_on_start", 64'(div_by_zero), 64'd0);

    // clr during CALC iteration 10: aborted op never completes
    wait_idle();
    op = 1'b0; a = 32'd11; b = 32'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_done", 64'(done), 64'd0);
    chk("clr_result", result, 64'd0);
    clr = 1'b0;
    @(negedge clk);

    // start held high through the whole op, operands wiggling: exactly one completion
    wait_idle();
    begin
      exp_t e;
      op = 1'b0; a = 32'd9; b = 32'hFFFF_FFFB; start = 1'b1;
      e.res = 64'hFFFF_FFFF_FFFF_FFD3; e.dbz = 1'b0; e.k = cyc + 1; e.lat = MUL_LAT;
      sb.push_back(e);
    end
    t = 0;
    do begin
      @(negedge clk);
      a = a + 32'd3; b = b ^ 32'h0F0F_0F0F; op = ~op;
      t++;
    end while (done !== 1'b1 && t < 100);
    start = 1'b0;
    if (t >= 100) chk("held_start_timeout", 64'd1, 64'd0);
    repeat (40) @(negedge clk);
    chk("held_start_idle", 64'(busy), 64'd0);

    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
